// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
// Holding-register handshake between the UART receive stage and its consumer.
//   master : the receiver   -- drives rx_data/rx_valid/error flags, samples rx_ack
//   slave  : the consumer   -- drives rx_ack, samples everything else
// Signals:
//   rx_ack       consumer has taken rx_data (clears rx_valid)
//   rx_data      last received word
//   rx_valid     rx_data holds an unread word
//   frame_err    stop bit of the word in rx_data sampled low
//   overrun_err  sticky; a word landed on top of an unread one
//   parity_err   parity mismatch on the word in rx_data (0 when parity is off)
// -----------------------------------------------------------------------------
interface uart_receiver_if #(
    parameter int DBITS = 8
);
    logic             rx_ack;
    logic [DBITS-1:0] rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             overrun_err;
    logic             parity_err;

    modport master (
        input  rx_ack,
        output rx_data, rx_valid, frame_err, overrun_err, parity_err
    );

    modport slave (
        output rx_ack,
        input  rx_data, rx_valid, frame_err, overrun_err, parity_err
    );
endinterface

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 16x-oversampled UART receive stage (8N1 by default). Recovers one frame at a
// time from the rx line and loads it into a holding register with a
// valid/ack handshake, plus framing and sticky overrun flags.
//
// Optional build macro: UART_RX_PARITY_EN
//   defined   -> one even-parity bit between the data bits and the stop bit,
//                checked into parity_err on load
//   undefined -> start + DBITS + stop, parity_err tied low
//
// Parameters:
//   DBITS    data bits per frame, LSB first (>= 2)
//   SB_TICK  oversampling ticks spent in the stop bit (1..16)
// Ports:
//   clk_100MHz   system clock
//   reset        asynchronous, active-high reset
//   sample_tick  one-clock pulse at 16x baud
//   rx           serial line, idle high, asynchronous to clk_100MHz
//   bus          holding-register handshake (master side)
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               sample_tick,
    input  logic               rx,
    uart_receiver_if.master    bus
);

    localparam int NB_W = (DBITS > 1) ? $clog2(DBITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // synchronizer
    logic             r_rx_meta;
    logic             r_rx_s;

    // frame FSM state
    state_t           r_state;
    logic [3:0]       r_tick;
    logic [NB_W-1:0]  r_nbits;
    logic [DBITS-1:0] r_shreg;
    // Set when a frame ends with the line still low (break); blocks a new
    // start until the line has been seen high again.
    logic             r_brk;
`ifdef UART_RX_PARITY_EN
    logic             r_par;
    logic             w_par_nx;
    logic             r_perr;
`endif

    // holding register
    logic [DBITS-1:0] r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             r_ovr;

    // next-state
    state_t           w_state_nx;
    logic [3:0]       w_tick_nx;
    logic [NB_W-1:0]  w_nbits_nx;
    logic [DBITS-1:0] w_shreg_nx;
    logic             w_load;

    always_comb begin
        w_state_nx = r_state;
        w_tick_nx  = r_tick;
        w_nbits_nx = r_nbits;
        w_shreg_nx = r_shreg;
        w_load     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nx   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                // falling edge detection needs no tick; counting starts here
                if (!r_rx_s && !r_brk) begin
                    w_state_nx = S_START;
                    w_tick_nx  = 4'd0;
                end
            end
            S_START: begin
                if (sample_tick) begin
                    if (r_tick == 4'd7) begin
                        // mid start bit: a high line here was only a glitch
                        if (!r_rx_s) begin
                            w_state_nx = S_DATA;
                            w_tick_nx  = 4'd0;
                            w_nbits_nx = '0;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_tick_nx = r_tick + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (sample_tick) begin
                    if (r_tick == 4'd15) begin
                        w_shreg_nx = {r_rx_s, r_shreg[DBITS-1:1]};
                        w_tick_nx  = 4'd0;
                        if (r_nbits == NB_W'(DBITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nx = S_PARITY;
`else
                            w_state_nx = S_STOP;
`endif
                        end else begin
                            w_nbits_nx = r_nbits + 1'b1;
                        end
                    end else begin
                        w_tick_nx = r_tick + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample_tick) begin
                    if (r_tick == 4'd15) begin
                        w_par_nx   = r_rx_s;
                        w_tick_nx  = 4'd0;
                        w_state_nx = S_STOP;
                    end else begin
                        w_tick_nx = r_tick + 4'd1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (sample_tick) begin
                    if (r_tick == 4'(SB_TICK - 1)) begin
                        w_load     = 1'b1;
                        w_tick_nx  = 4'd0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_tick_nx = r_tick + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_tick_nx  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= S_IDLE;
            r_tick    <= 4'd0;
            r_nbits   <= '0;
            r_shreg   <= '0;
            r_brk     <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_state_nx;
            r_tick    <= w_tick_nx;
            r_nbits   <= w_nbits_nx;
            r_shreg   <= w_shreg_nx;
`ifdef UART_RX_PARITY_EN
            r_par     <= w_par_nx;
`endif

            if (w_load && !r_rx_s)
                r_brk <= 1'b1;
            else if (r_rx_s)
                r_brk <= 1'b0;

            if (w_load) begin
                // newest word always wins; an unacked older word flags overrun
                r_data  <= r_shreg;
                r_ferr  <= ~r_rx_s;
                r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                r_perr  <= (^r_shreg) ^ r_par;
`endif
                if (r_valid && !bus.rx_ack)
                    r_ovr <= 1'b1;
                else if (bus.rx_ack)
                    r_ovr <= 1'b0;
            end else if (bus.rx_ack) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign bus.rx_data     = r_data;
    assign bus.rx_valid    = r_valid;
    assign bus.frame_err   = r_ferr;
    assign bus.overrun_err = r_ovr;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = r_perr;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed + random frames driven onto rx; a frame-level model of the holding
// register (data, valid, framing, overrun, parity) supplies every expectation.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int BIT_CLKS = 64;  // 16 ticks per bit, tick every 4 clocks

    logic clk;
    logic reset;
    logic sample_tick;
    logic rx;

    uart_receiver_if #(.DBITS(8)) bus ();

    uart_receiver #(.DBITS(8), .SB_TICK(16)) dut (
        .clk_100MHz  (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rx          (rx),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    // frame-level reference of the holding register
    logic [7:0] exp_data;
    logic       exp_valid, exp_ferr, exp_ovr, exp_perr;

    bit seen_a5 = 1'b0;
    always @(negedge clk)
        if (bus.rx_valid && bus.rx_data == 8'hA5) seen_a5 = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},   32'(bus.rx_data),     32'(exp_data));
        chk({tag, ".valid"},  32'(bus.rx_valid),    32'(exp_valid));
        chk({tag, ".ferr"},   32'(bus.frame_err),   32'(exp_ferr));
        chk({tag, ".ovr"},    32'(bus.overrun_err), 32'(exp_ovr));
        chk({tag, ".perr"},   32'(bus.parity_err),  32'(exp_perr));
    endtask

    task automatic model_reset();
        exp_data = 8'h00; exp_valid = 1'b0; exp_ferr = 1'b0;
        exp_ovr = 1'b0; exp_perr = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit stopb, input bit parb);
        if (exp_valid) exp_ovr = 1'b1;
        exp_valid = 1'b1;
        exp_data  = b;
        exp_ferr  = !stopb;
        exp_perr  = PAR_EN ? ((^b) ^ parb) : 1'b0;
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stopb, input bit parb);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        if (PAR_EN) bit_time(parb);
        bit_time(stopb);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        model_frame(b, stopb, parb);
    endtask

    task automatic ack();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        @(negedge clk);
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        bit         rs, rp;

        reset = 1'b1;
        rx = 1'b1;
        bus.rx_ack = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_all("por");
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // reset mid-frame: 0xA5 cut off in data bit 3
        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(1'(8'hA5 >> i));
        rx = 1'(8'hA5 >> 3);
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        model_reset();
        check_all("midrst");
        rx = 1'b1;
        reset = 1'b0;
        repeat (4 * BIT_CLKS) @(negedge clk);
        check_all("midrst_idle");
        send_frame(8'h3C, 1'b1, 1'b0);
        check_all("after_rst_3c");
        chk("no_a5", 32'(seen_a5), 32'd0);
        ack();
        check_all("ack_3c");

        // nominal
        send_frame(8'h55, 1'b1, 1'b0);
        check_all("nom_55");
        ack();
        check_all("nom_55_ack");
        send_frame(8'hA3, 1'b1, 1'b0);
        check_all("nom_a3");
        ack();

        // glitch: 5 ticks low
        rx = 1'b0;
        repeat (5 * 4) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT_CLKS) @(negedge clk);
        check_all("glitch");
        send_frame(8'hC6, 1'b1, 1'b0);
        check_all("post_glitch");
        ack();

        // framing error
        send_frame(8'h81, 1'b0, 1'b0);
        check_all("frame_81");
        ack();

        // overrun
        send_frame(8'h11, 1'b1, 1'b1);
        check_all("ovr_11");
        send_frame(8'h22, 1'b1, 1'b0);
        check_all("ovr_22");
        ack();
        check_all("ovr_ack");

        // break: long low, one zero word with frame error, then nothing more
        rx = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        model_frame(8'h00, 1'b0, 1'b0);
        check_all("break");
        ack();
        repeat (10 * BIT_CLKS) @(negedge clk);
        check_all("break_hold");
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b0);
        check_all("after_break");
        ack();

        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b1);
            check_all("par_ok");
            ack();
            send_frame(8'h07, 1'b1, 1'b0);
            check_all("par_bad");
            ack();
        end

        // random frames, random acks
        for (int k = 0; k < 10; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            rp = (^rb) ^ ($urandom_range(0, 3) == 0);
            send_frame(rb, rs, rp);
            check_all($sformatf("rnd%0d", k));
            if ($urandom_range(0, 1) == 1) begin
                ack();
                check_all($sformatf("rnd%0d_ack", k));
            end
        end
        ack();
        check_all("final_ack");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
